// File: rtl/pool_unit_pkg.sv
// Shared widths, FSM encodings and the requantisation function for the pooling unit.
package pool_pkg;

    localparam int NUM_PEB    = 16;
    localparam int PSUM_WIDTH = 32;
    localparam int ACT_WIDTH  = 8;
    localparam int ADDR_WIDTH = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FNH   = 2'd3;

    // Saturation bounds expressed at the widened (PSUM_WIDTH+1) working width.
    localparam logic signed [PSUM_WIDTH:0] ACT_MAX = (PSUM_WIDTH+1)'(2**(ACT_WIDTH-1) - 1);
    localparam logic signed [PSUM_WIDTH:0] ACT_MIN = (PSUM_WIDTH+1)'(-(2**(ACT_WIDTH-1)));

    // Optional ReLU, round-half-up arithmetic right shift, then signed saturation.
    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [ACT_WIDTH-1:0] sat_shift(input logic signed [PSUM_WIDTH-1:0] m,
                                                       input logic [4:0]                   shift,
                                                       input logic                         relu);
        logic signed [PSUM_WIDTH:0] r;
        logic signed [PSUM_WIDTH:0] rnd;
        logic        [ACT_WIDTH-1:0] res;
        r = {m[PSUM_WIDTH-1], m};
        if (relu && r[PSUM_WIDTH]) begin
            r = '0;
        end
        rnd = (shift == 5'd0) ? '0 : ((PSUM_WIDTH+1)'(1) <<< (shift - 5'd1));
        r = (r + rnd) >>> shift;
        if (r > ACT_MAX) begin
            res = ACT_MAX[ACT_WIDTH-1:0];
        end else if (r < ACT_MIN) begin
            res = ACT_MIN[ACT_WIDTH-1:0];
        end else begin
            res = r[ACT_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_unit_if.sv
// GB_PSUM read port and activation output stream of the pooling unit.
interface pool_gb_if;
    import pool_pkg::*;

    logic                          POOLGB_rdy;
    logic [ADDR_WIDTH-1:0]         POOLGB_addr;
    logic                          GBPOOL_val;
    logic [PSUM_WIDTH*NUM_PEB-1:0] GBPOOL_data;

    // master: the pooling unit issuing reads; slave: the global buffer
    modport master (output POOLGB_rdy, POOLGB_addr, input GBPOOL_val, GBPOOL_data);
    modport slave  (input POOLGB_rdy, POOLGB_addr, output GBPOOL_val, GBPOOL_data);
endinterface

interface pool_out_if;
    import pool_pkg::*;

    logic                         POOLOUT_val;
    logic [ACT_WIDTH*NUM_PEB-1:0] POOLOUT_data;
    logic                         OUTPOOL_rdy;

    // master: the pooling unit producing words; slave: the downstream consumer
    modport master (output POOLOUT_val, POOLOUT_data, input OUTPOOL_rdy);
    modport slave  (input POOLOUT_val, POOLOUT_data, output OUTPOOL_rdy);
endinterface

// File: rtl/pool_unit_lane.sv
// One pooling lane: running signed max over the window plus requantisation of
// the max that includes the current beat.
module pool_lane
    import pool_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rstn,
    input  logic                  beat_i,
    input  logic                  first_i,
    input  logic [PSUM_WIDTH-1:0] d_i,
    input  logic [4:0]            shift_i,
    input  logic                  relu_i,
    output logic [ACT_WIDTH-1:0]  act_o
);

    logic signed [PSUM_WIDTH-1:0] acc_q;
    logic signed [PSUM_WIDTH-1:0] acc_d;
    logic signed [PSUM_WIDTH-1:0] d_s;

    assign d_s = d_i;

    // First beat of a window restarts the max; later beats keep the larger value.
    always_comb begin
        acc_d = acc_q;
        if (first_i || (d_s > acc_q)) begin
            acc_d = d_s;
        end
    end

    // Accumulator only advances on an accepted beat.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            acc_q <= '0;
        end else if (beat_i) begin
            acc_q <= acc_d;
        end
    end

    assign act_o = sat_shift(acc_d, shift_i, relu_i);

endmodule

// File: rtl/pool_unit.sv
// Pooling unit: reads a psum patch from GB_PSUM, max-pools each lane over a
// window of beats, requantises, and streams one activation word per window.
//
//   state | meaning
//   IDLE  | waiting for CCUPOOL_start
//   READ  | issuing reads, pooling beats, closing windows
//   DRAIN | last beat taken, waiting for the output register to empty
//   FNH   | one-cycle POOLGB_fnh pulse
module pool_unit
    import pool_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rstn,
    input  logic                  CCUPOOL_start,
    input  logic [ADDR_WIDTH-1:0] CFGPOOL_num_addr,
    input  logic [2:0]            CFGPOOL_win,
    input  logic [4:0]            CFGPOOL_shift,
    input  logic                  CFGPOOL_relu,
    pool_gb_if.master             gb,
    pool_out_if.master            po,
    output logic                  POOLGB_fnh,
    output logic                  POOLCCU_busy
);

    logic [1:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        num_addr_q;
    logic [2:0]                   win_q;
    logic [4:0]                   shift_q;
    logic                         relu_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [2:0]                   win_cnt_q;
    logic                         out_val_q;
    logic [ACT_WIDTH*NUM_PEB-1:0] out_data_q;
    logic [ACT_WIDTH*NUM_PEB-1:0] act_word;

    logic rd_rdy, beat, last_beat, close, take, start_ok;

    assign start_ok  = (state_q == ST_IDLE) && CCUPOOL_start;
    assign rd_rdy    = (state_q == ST_READ) && !(out_val_q && !po.OUTPOOL_rdy);
    assign beat      = rd_rdy && gb.GBPOOL_val;
    assign last_beat = beat && (addr_q == num_addr_q);
    assign close     = beat && ((win_cnt_q == win_q) || (addr_q == num_addr_q));
    assign take      = out_val_q && po.OUTPOOL_rdy;

    // Next-state selection for the patch sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (CCUPOOL_start) state_d = ST_READ;
            ST_READ:  if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (!out_val_q || take) state_d = ST_FNH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM, latched configuration and the address/window counters.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q    <= ST_IDLE;
            num_addr_q <= '0;
            win_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            addr_q     <= '0;
            win_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                num_addr_q <= CFGPOOL_num_addr;
                win_q      <= CFGPOOL_win;
                shift_q    <= CFGPOOL_shift;
                relu_q     <= CFGPOOL_relu;
                addr_q     <= '0;
                win_cnt_q  <= '0;
            end else if (beat) begin
                addr_q    <= addr_q + 1'b1;
                win_cnt_q <= close ? 3'd0 : win_cnt_q + 3'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PEB; i++) begin : g_lane
        pool_lane u_lane (
            .Clk     (Clk),
            .Rstn    (Rstn),
            .beat_i  (beat),
            .first_i (win_cnt_q == 3'd0),
            .d_i     (gb.GBPOOL_data[i*PSUM_WIDTH +: PSUM_WIDTH]),
            .shift_i (shift_q),
            .relu_i  (relu_q),
            .act_o   (act_word[i*ACT_WIDTH +: ACT_WIDTH])
        );
    end

    // Output register: a closing window loads (even while the old word is taken),
    // otherwise a handshake empties it.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            out_val_q  <= 1'b0;
            out_data_q <= '0;
        end else if (close) begin
            out_val_q  <= 1'b1;
            out_data_q <= act_word;
        end else if (take) begin
            out_val_q  <= 1'b0;
        end
    end

    assign gb.POOLGB_rdy   = rd_rdy;
    assign gb.POOLGB_addr  = addr_q;
    assign po.POOLOUT_val  = out_val_q;
    assign po.POOLOUT_data = out_data_q;
    assign POOLGB_fnh      = (state_q == ST_FNH);
    assign POOLCCU_busy    = (state_q != ST_IDLE);

endmodule
